// File: rtl/adc_sim_pkg.sv
// adc_sim_pkg: mode encoding, PN9 seed and checkerboard constants shared by the ADC pattern source
package adc_sim_pkg;
  typedef enum logic [2:0] {RAMP, MIDSCALE, POS_FS, NEG_FS, CHECKER, PN9, USER, TOGGLE} adc_mode_e;
  localparam logic [8:0]  PN9_SEED = 9'h1FF;
  localparam logic [15:0] CHK_A    = 16'h5555;
  localparam logic [15:0] CHK_B    = 16'hAAAA;
endpackage

// File: rtl/adc_pn9_lfsr.sv
// adc_pn9_lfsr: PN9 (x^9+x^5+1) generator; clk, rst (async high), step advances, state[8:0] current value
module adc_pn9_lfsr
  import adc_sim_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [8:0] state
);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= PN9_SEED;
    else if (step) state <= {state[7:0], state[8] ^ state[4]};
endmodule

// File: rtl/adc_pattern_src.sv
// adc_pattern_src: multi-channel ADC ramp/test-pattern source with LATENCY-deep output pipeline
//   ports: clk, rst (async high), en, mode[2:0], ovr_en, user_pat[4*DATA_W], data[CH_NUM*DATA_W], or_flag[CH_NUM], valid
//   ADC_PN_GEN_EN defined: PN9 in mode 5; undefined: mode 5 gives midscale
module adc_pattern_src
  import adc_sim_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int CH_NUM  = 2,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic                     ovr_en,
  input  logic [4*DATA_W-1:0]      user_pat,
  output logic [CH_NUM*DATA_W-1:0] data,
  output logic [CH_NUM-1:0]        or_flag,
  output logic                     valid
);
  localparam logic [DATA_W-1:0] ONES = '1;
  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W:0] cnt, cnt_nxt, v;
  logic [2:0] mode_q;
  logic mode_chg, ph, ph_cur;
  logic [1:0] idx, idx_cur;
  logic [DATA_W-1:0] pat, pn_pat;
  logic [CH_NUM*DATA_W-1:0] smp;
  logic [CH_NUM-1:0] smp_or;
  logic [CH_NUM*DATA_W-1:0] pd [LATENCY];
  logic [CH_NUM-1:0] po [LATENCY];
  logic [LATENCY-1:0] pv;
`ifdef ADC_PN_GEN_EN
  logic [8:0] pn;
  adc_pn9_lfsr u_pn (.clk(clk), .rst(rst), .step(en), .state(pn));
  assign pn_pat = DATA_W'(pn);
`else
  assign pn_pat = MID;
`endif
  // phase/index restart on the first cycle of a new mode without waiting a clock
  always_comb begin
    mode_chg = mode != mode_q;
    ph_cur = ph & ~mode_chg;
    idx_cur = mode_chg ? 2'd0 : idx;
    pat = mode == MIDSCALE ? MID :
          mode == POS_FS   ? ONES :
          mode == CHECKER  ? (ph_cur ? CHK_B[DATA_W-1:0] : CHK_A[DATA_W-1:0]) :
          mode == PN9      ? pn_pat :
          mode == USER     ? user_pat[idx_cur*DATA_W +: DATA_W] :
          mode == TOGGLE   ? (ph_cur ? '0 : ONES) : '0;
    // without ovr_en a leftover overrange count collapses to 0 on the next step
    cnt_nxt = ovr_en ? cnt + (DATA_W+1)'(1) : cnt[DATA_W] ? '0 : {1'b0, cnt[DATA_W-1:0] + DATA_W'(1)};
    v = '0;
    smp = '0;
    smp_or = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      v = ovr_en ? cnt + (DATA_W+1)'(c) : {1'b0, cnt[DATA_W-1:0] + DATA_W'(c)};
      smp[c*DATA_W +: DATA_W] = mode != RAMP ? pat : v[DATA_W] ? ONES : v[DATA_W-1:0];
      smp_or[c] = mode == RAMP && v[DATA_W];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      mode_q <= RAMP;
      ph <= 1'b0;
      idx <= 2'd0;
    end else begin
      mode_q <= mode;
      ph <= ph_cur ^ en;
      idx <= idx_cur + {1'b0, en};
      if (en) cnt <= cnt_nxt;
    end
  // stage 0 keeps its last sample while en is low; later stages always shift
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pd[i] <= '0;
        po[i] <= '0;
      end
      pv <= '0;
    end else begin
      if (en) begin
        pd[0] <= smp;
        po[0] <= smp_or;
      end
      pv[0] <= en;
      for (int i = 1; i < LATENCY; i++) begin
        pd[i] <= pd[i-1];
        po[i] <= po[i-1];
        pv[i] <= pv[i-1];
      end
    end
  assign data = pd[LATENCY-1];
  assign or_flag = po[LATENCY-1];
  assign valid = pv[LATENCY-1];
endmodule

// File: tb/tb_adc_pattern_src.sv
// tb_adc_pattern_src: directed and randomized checks of adc_pattern_src against a behavioural model
module tb_adc_pattern_src;
  localparam int W = 14, CH = 2, LAT = 2;
  logic clk = 0, rst = 1, en = 0, ovr_en = 0;
  logic [2:0] mode = 0;
  logic [4*W-1:0] user_pat = '0;
  logic [CH*W-1:0] data;
  logic [CH-1:0] or_flag;
  logic valid;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  adc_pattern_src #(.DATA_W(W), .CH_NUM(CH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ovr_en(ovr_en),
    .user_pat(user_pat), .data(data), .or_flag(or_flag), .valid(valid));
  typedef struct packed {logic [CH*W-1:0] d; logic [CH-1:0] o; logic v;} st_t;
  st_t hist[$];
  st_t expd;
  int m_cnt, m_k, t_md, t_v;
  logic [8:0] m_pn;
  logic [2:0] m_prev;
  logic [CH*W-1:0] last_d;
  logic [CH-1:0] last_o;
  // k = enabled cycles already spent in the current mode
  function automatic logic [W-1:0] common(logic [2:0] md, int k);
    logic [15:0] c5 = 16'h5555;
    logic [15:0] ca = 16'hAAAA;
    logic [W-1:0] ones = '1;
    logic [W-1:0] mid = '0;
    mid[W-1] = 1'b1;
    case (md)
      3'd1: return mid;
      3'd2: return ones;
      3'd4: return (k % 2) ? ca[W-1:0] : c5[W-1:0];
`ifdef ADC_PN_GEN_EN
      3'd5: return W'(m_pn);
`else
      3'd5: return mid;
`endif
      3'd6: return user_pat[(k % 4)*W +: W];
      3'd7: return (k % 2) ? '0 : ones;
      default: return '0;
    endcase
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_k = 0; m_pn = 9'h1FF; m_prev = 0;
      last_d = '0; last_o = '0;
      hist.delete();
    end else begin
      if (mode != m_prev) m_k = 0;
      m_prev = mode;
      if (en)
        for (int c = 0; c < CH; c++) begin
          if (mode == 0) begin
            t_md = ovr_en ? (1 << (W+1)) : (1 << W);
            t_v = (m_cnt + c) % t_md;
            last_d[c*W +: W] = (t_v >= (1 << W)) ? '1 : W'(t_v);
            last_o[c] = t_v >= (1 << W);
          end else begin
            last_d[c*W +: W] = common(mode, m_k);
            last_o[c] = 1'b0;
          end
        end
      hist.push_back({last_d, last_o, en});
      if (hist.size() > LAT) hist.pop_front();
      if (en) begin
        m_cnt = ovr_en ? (m_cnt + 1) % (1 << (W+1)) : (m_cnt >= (1 << W)) ? 0 : (m_cnt + 1) % (1 << W);
        m_pn = {m_pn[7:0], m_pn[8] ^ m_pn[4]};
        m_k++;
      end
    end
  end
  always @(negedge clk) begin
    expd = (hist.size() == LAT) ? hist[0] : '0;
    checks++;
    if ({data, or_flag, valid} !== expd) begin
      failures++;
      $display("FAIL model t=%0t: data=%h or=%b valid=%b, expected data=%h or=%b valid=%b",
               $time, data, or_flag, valid, expd.d, expd.o, expd.v);
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  task automatic wait_cnt(input int target);
    for (int i = 0; i < 70000; i++) begin
      if (m_cnt == target) return;
      @(negedge clk);
    end
    failures++;
    $display("FAIL wait_cnt: count %h not reached", target);
  endtask
  task automatic nx;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) nx;
    rst = 0; en = 1; mode = 0; ovr_en = 0;
    nx;
    chk("first_not_valid", valid, 0);
    nx;
    chk("first_valid", valid, 1);
    chk("ramp0_ch0", data[W-1:0], 14'h0000);
    chk("ramp0_ch1", data[2*W-1:W], 14'h0001);
    nx;
    chk("ramp1_ch0", data[W-1:0], 14'h0001);
    chk("ramp1_ch1", data[2*W-1:W], 14'h0002);
    chk("ramp1_or", or_flag, 2'b00);
    ovr_en = 1;
    wait_cnt(14'h3FFE);
    nx; nx;
    chk("ovr_3ffe_ch0", data[W-1:0], 14'h3FFE);
    chk("ovr_3ffe_or", or_flag, 2'b00);
    nx;
    chk("ovr_3fff_ch0", data[W-1:0], 14'h3FFF);
    chk("ovr_3fff_ch1", data[2*W-1:W], 14'h3FFF);
    chk("ovr_3fff_or", or_flag, 2'b10);
    nx;
    chk("ovr_4000_ch0", data[W-1:0], 14'h3FFF);
    chk("ovr_4000_or", or_flag, 2'b11);
    wait_cnt(15'h7FFF);
    nx; nx;
    chk("wrap_7fff_ch1", data[2*W-1:W], 14'h0000);
    chk("wrap_7fff_or", or_flag, 2'b01);
    nx;
    chk("wrap_0_ch0", data[W-1:0], 14'h0000);
    chk("wrap_0_or", or_flag, 2'b00);
    ovr_en = 0;
    wait_cnt(14'h3FFF);
    nx; nx;
    chk("noovr_ch0", data[W-1:0], 14'h3FFF);
    chk("noovr_ch1", data[2*W-1:W], 14'h0000);
    chk("noovr_or", or_flag, 2'b00);
    nx;
    chk("noovr_wrap_ch0", data[W-1:0], 14'h0000);
    ovr_en = 1;
    wait_cnt(15'h4002);
    ovr_en = 0;
    nx; nx;
    chk("ovrfall_ch0", data[W-1:0], 14'h0002);
    chk("ovrfall_or", or_flag, 2'b00);
    nx;
    chk("ovrfall_load0", data[W-1:0], 14'h0000);
    user_pat = {14'h0044, 14'h0033, 14'h0022, 14'h0011};
    mode = 6;
    nx; nx;
    chk("user_1", data, {14'h0011, 14'h0011});
    en = 0;
    nx;
    chk("user_2", data, {14'h0022, 14'h0022});
    nx;
    chk("user_hold_v", valid, 0);
    nx;
    en = 1;
    nx;
    chk("user_hold_v3", valid, 0);
    nx;
    chk("user_3", data, {14'h0033, 14'h0033});
    nx;
    chk("user_4", data, {14'h0044, 14'h0044});
    nx;
    chk("user_wrap", data, {14'h0011, 14'h0011});
    mode = 4;
    nx; nx;
    chk("chk_a", data[W-1:0], 14'h1555);
    mode = 7;
    nx;
    chk("chk_b", data[W-1:0], 14'h2AAA);
    nx;
    chk("tog_ones", data[W-1:0], 14'h3FFF);
    mode = 4;
    nx;
    chk("tog_zero", data[W-1:0], 14'h0000);
    nx;
    chk("chk_restart", data[W-1:0], 14'h1555);
    #2 rst = 1;
    #1;
    chk("rst_data", data, 0);
    chk("rst_or", or_flag, 0);
    chk("rst_valid", valid, 0);
    nx; nx;
    rst = 0; mode = 5; en = 1;
    nx; nx;
`ifdef ADC_PN_GEN_EN
    chk("pn_0", data[W-1:0], 14'h01FF);
    nx;
    chk("pn_1", data[W-1:0], 14'h01FE);
    nx;
    chk("pn_2", data[W-1:0], 14'h01FC);
    nx;
    chk("pn_3", data[W-1:0], 14'h01F8);
`else
    chk("pn_0", data[W-1:0], 14'h2000);
    nx;
    chk("pn_1", data[W-1:0], 14'h2000);
    nx;
    chk("pn_2", data[2*W-1:W], 14'h2000);
`endif
    for (int i = 0; i < 3000; i++) begin
      nx;
      en = $urandom_range(3) != 0;
      if ($urandom_range(7) == 0) mode = 3'($urandom_range(7));
      if ($urandom_range(31) == 0) ovr_en = ~ovr_en;
      if ($urandom_range(15) == 0) user_pat = {$urandom, $urandom};
      if ($urandom_range(199) == 0) begin
        #2 rst = 1;
        nx;
        rst = 0;
      end
    end
    nx;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_pattern_src.md
# adc_pattern_src

Parametrised multi-channel ADC sample source for the DSP testbench; the successor to the single-channel 14-bit ADC model's data/test-pattern path. It generates `CH_NUM` channels of `DATA_W`-bit samples per clock: ramp with optional overrange excursion, or one of the fixed test patterns. Output passes through a `LATENCY`-deep pipeline with per-channel overrange flags and a valid strobe, ready to feed a DDR/LVDS serializer model or the receiver under test directly.

## Interface
- `DATA_W`, 14, sample width; legal 8..16.
- `CH_NUM`, 2, channel count; legal 1..8.
- `LATENCY`, 2, cycles from enabled input cycle to output; legal 1..8.
- `clk`  in  1  sample clock. One clock only.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  advance generators; sampled each `clk`.
- `mode`  in  3  pattern select (see Operation).
- `ovr_en`  in  1  allow ramp to enter overrange region.
- `user_pat`  in  4*DATA_W  user patterns 1..4; pattern k in bits `[k*DATA_W-1 -: DATA_W]`.
- `data`  out  CH_NUM*DATA_W  samples; channel c in bits `[(c+1)*DATA_W-1 -: DATA_W]`.
- `or_flag`  out  CH_NUM  per-channel overrange, aligned with `data`.
- `valid`  out  1  `data`/`or_flag` carry an enabled sample.

## Operation
- Ramp counter `cnt`, DATA_W+1 bits, reset 0; increments by 1 on each `en` cycle in every mode.
- `ovr_en`=1: `cnt` wraps 2^(DATA_W+1)-1 -> 0. `ovr_en`=0: `cnt` wraps (2^DATA_W)-1 -> 0; if `cnt`[DATA_W] is already set when `ovr_en` falls, the next `en` cycle loads 0.
- Channel raw value `v_c = cnt + c`, DATA_W+1 bits, mod 2^(DATA_W+1) when `ovr_en`=1, mod 2^DATA_W when 0.
- Mode 0, ramp: `v_c`[DATA_W]=1 -> sample all ones, `or`=1. Otherwise sample `v_c`[DATA_W-1:0], `or`=0.
- Mode 1, midscale: 1<<(DATA_W-1).
- Mode 2, +FS: all ones.
- Mode 3, -FS: 0.
- Mode 4, checkerboard: alternates 0b..0101 / 0b..1010. Phase reg starts at 0101.
- Mode 5, PN9: x^9+x^5+1, seed 9'h1FF. Each `en` cycle: `s <= {s[7:0], s[8]^s[4]}`. Sample = `s` zero-extended to DATA_W, truncated to low 8 bits if DATA_W=8.
- Mode 6, user: cycles patterns 1->2->3->4->1 on each `en` cycle. Index starts at 1.
- Mode 7, toggle: all ones / all zeros alternately, starting all ones.
- Modes 1-7: same sample on all channels, `or`=0.
- Any change of `mode` (registered compare) resets the checkerboard/toggle phase and user index to start values on the first cycle in the new mode. The PN state is not reset.
- `en`=0: `cnt`, PN, phase and index hold. Stage 0 holds its previous sample with valid=0. The pipeline keeps shifting.

## Timing
- Stage 0 registers the generated sample, `or` and `en`. `LATENCY-1` further register stages follow; `data`/`or_flag`/`valid` are the last stage.
- Sample generated from state at edge N appears at edge N+LATENCY-1 outputs, i.e. LATENCY cycles after `en` sampled high.
- Reset values: `data`=0, `or_flag`=0, `valid`=0, `cnt`=0, PN=9'h1FF, phase/index = start values. All pipeline stages are cleared.
- Reset mid-run clears everything immediately (async). The first valid sample appears LATENCY cycles after the first `en` following deassertion.
- `mode`/`ovr_en` changes take effect on the sample generated at the same edge they are sampled.

## Configuration
- `ADC_PN_GEN_EN` defined: PN9 generator and mode 5 as above.
- Not defined: no LFSR logic; mode 5 outputs midscale with `or`=0.

## Structure
- Package `adc_sim_pkg`:
  - mode enum `adc_mode_e` (RAMP, MIDSCALE, POS_FS, NEG_FS, CHECKER, PN9, USER, TOGGLE);
  - `PN9_SEED`=9'h1FF;
  - checkerboard base constants.
- Sub-module `adc_pn9_lfsr` (clk, rst, step, state[8:0]), instantiated only under `ADC_PN_GEN_EN`.

## Test plan
Defaults: DATA_W=14, CH_NUM=2, LATENCY=2.
- Reset released, mode 0, `en`=1: first `valid` 2 cycles later. ch0=0x0000, ch1=0x0001; next ch0=0x0001, ch1=0x0002; `or_flag`=0.
- `ovr_en`=1, ramp through `cnt`=0x3FFE..0x4000:
  - ch0 0x3FFE, 0x3FFF, 0x3FFF; `or_flag[0]` 0,0,1.
  - ch1 `or_flag[1]` rises one cycle earlier.
  - After `cnt`=0x7FFF, ch0 returns to 0x0000 with `or`=0.
- `ovr_en`=0 at `cnt`=0x3FFF: ch0=0x3FFF, ch1=0x0000, next ch0=0x0000; `or_flag` never set.
- Mode 6 with user_pat = 0x0011/0x0022/0x0033/0x0044 (patterns 1..4): outputs 0x0011, 0x0022, 0x0033, 0x0044, 0x0011. `en` low 3 cycles mid-sequence: `valid`=0 for those cycles, then the sequence resumes at the next pattern.
- Mode 5 with `ADC_PN_GEN_EN`: outputs 0x01FF, 0x01FE, 0x01FC, 0x01F8. Without the macro: 0x2000 constant.
- Mode 4 -> 7 -> 4: 0x1555, 0x2AAA, then 0x3FFF, 0x0000, then 0x1555 again. Assert `rst` mid-stream: all outputs 0 immediately.
